// File: rtl/sample_collector_if.sv
// Bus bundle for sample_collector: memory read port, sample stream out, control/status.
// Carries o_sum only when SAMPLE_COLLECTOR_SUM_EN is defined.
interface sample_collector_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 100
);
  localparam int SUM_WIDTH = DATA_WIDTH + $clog2(DEPTH) + 1;

  logic                  i_start;
  logic [ADDR_WIDTH-1:0] i_base_addr;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic                  o_rd_en;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_busy;
  logic                  o_done;
  logic [1:0]            o_state;
`ifdef SAMPLE_COLLECTOR_SUM_EN
  logic [SUM_WIDTH-1:0]  o_sum;
`endif

  // Stream handshake: a sample moves when o_valid & i_ready are both high on a
  // rising edge; o_valid never drops and o_data never changes while i_ready is low.
  modport master (
    input  i_start, i_base_addr, i_data, i_ready,
    output o_addr, o_rd_en, o_data, o_valid, o_busy, o_done, o_state
`ifdef SAMPLE_COLLECTOR_SUM_EN
    , output o_sum
`endif
  );

  modport slave (
    output i_start, i_base_addr, i_data, i_ready,
    input  o_addr, o_rd_en, o_data, o_valid, o_busy, o_done, o_state
`ifdef SAMPLE_COLLECTOR_SUM_EN
    , input o_sum
`endif
  );
endinterface

// File: rtl/sample_collector.sv
// Reads DEPTH strided words from a synchronous memory into a shift buffer, then streams them oldest-first.
// Optional running block sum on o_sum when SAMPLE_COLLECTOR_SUM_EN is defined.
module sample_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 100,
  parameter int STRIDE     = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sample_collector_if.master bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [IW-1:0]         LAST_IDX = IW'(DEPTH - 1);
  localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(STRIDE);
`ifdef SAMPLE_COLLECTOR_SUM_EN
  localparam int SUM_WIDTH = DATA_WIDTH + $clog2(DEPTH) + 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rd_en;
  logic                  r_cap_en;
  logic [IW-1:0]         r_rd_cnt;
  logic [IW-1:0]         r_wr_cnt;
  logic [CW-1:0]         r_rem;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_buf [DEPTH];
  logic                  w_accept;
  logic                  w_hs;
  logic                  w_last_hs;

  assign w_accept  = (r_state == S_IDLE) && bus.i_start;
  assign w_hs      = (r_state == S_OUT) && r_valid && bus.i_ready;
  assign w_last_hs = w_hs && (r_rem == CW'(1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_next = S_FETCH;
      S_FETCH: if (r_rd_cnt == LAST_IDX) w_next = S_DRAIN;
      S_DRAIN: w_next = S_OUT;
      S_OUT:   if (w_last_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_addr   <= '0;
      r_rd_en  <= 1'b0;
      r_cap_en <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_rem    <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_rd_en  <= (w_next == S_FETCH);
      r_valid  <= (w_next == S_OUT);
      r_busy   <= (w_next != S_IDLE);
      r_done   <= w_last_hs;
      // Read data returns one cycle after each strobe.
      r_cap_en <= r_rd_en;

      if (w_accept) begin
        r_addr   <= bus.i_base_addr;
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
      end else if (r_state == S_FETCH && w_next == S_FETCH) begin
        r_addr   <= r_addr + STEP;
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end

      if (r_cap_en) begin
        r_buf[r_wr_cnt] <= bus.i_data;
        r_wr_cnt        <= r_wr_cnt + 1'b1;
      end

      if (r_state == S_DRAIN) begin
        r_rem <= FULL_CNT;
      end else if (w_hs) begin
        r_rem <= r_rem - 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) r_buf[i] <= r_buf[i+1];
        r_buf[DEPTH-1] <= '0;
      end
    end
  end

`ifdef SAMPLE_COLLECTOR_SUM_EN
  logic [SUM_WIDTH-1:0] r_sum;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)        r_sum <= '0;
    else if (w_accept) r_sum <= '0;
    else if (r_cap_en) r_sum <= r_sum + SUM_WIDTH'(bus.i_data);
  end

  assign bus.o_sum = r_sum;
`endif

  assign bus.o_addr  = r_addr;
  assign bus.o_rd_en = r_rd_en;
  assign bus.o_data  = r_buf[0];
  assign bus.o_valid = r_valid;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
  assign bus.o_state = r_state;
endmodule
